// File: rtl/nm_cmd_pkg.sv
// rtl/nm_cmd_pkg.sv - shared types and helpers for the C2N command scheduler
package nm_cmd_pkg;

    // Default command word width on the C2N links
    localparam int CMD_W_DEF = 32;

    // Per-channel serializer states
    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_SHIFT = 2'd1,
        CH_GAP   = 2'd2
    } nm_ch_state_t;

    // Width of a requester index; never narrower than one bit
    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/nm_cmd_sched_if.sv
// rtl/nm_cmd_sched_if.sv - requester-side command bus of the C2N scheduler
interface nm_cmd_sched_if
    import nm_cmd_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int CMD_W = CMD_W_DEF
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_chan;
    logic [NREQ*CMD_W-1:0] req_cmd;
    logic [NREQ-1:0]       req_ready;

    // Command sources drive valid/chan/cmd and watch ready
    modport master (
        output req_valid,
        output req_chan,
        output req_cmd,
        input  req_ready
    );

    // Scheduler side
    modport slave (
        input  req_valid,
        input  req_chan,
        input  req_cmd,
        output req_ready
    );
endinterface

// File: rtl/nm_rr_arb.sv
// rtl/nm_rr_arb.sv - round-robin arbiter, search starts after the last winner
module nm_rr_arb
    import nm_cmd_pkg::*;
#(
    parameter  int NREQ = 3,
    localparam int ID_W = id_w(NREQ)
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_index
);

    logic [ID_W-1:0] r_last;
    logic [ID_W:0]   w_cand_idx;
    logic            w_found;

    // Scan requesters from r_last+1 upward with wrap, first hit wins
    always_comb begin
        w_found    = 1'b0;
        o_index    = '0;
        o_grant    = '0;
        w_cand_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand_idx = {1'b0, r_last} + (ID_W+1)'(k);
            if (w_cand_idx >= (ID_W+1)'(NREQ))
                w_cand_idx = w_cand_idx - (ID_W+1)'(NREQ);
            if (!w_found && i_req[w_cand_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                o_index = w_cand_idx[ID_W-1:0];
            end
        end
        if (w_found)
            o_grant[o_index] = 1'b1;
    end

    // Pointer moves only when the grant is actually taken; reset favours requester 0
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            r_last <= ID_W'(NREQ-1);
        else if (i_advance && w_found)
            r_last <= o_index;
    end

endmodule

// File: rtl/nm_cmd_sched.sv
// rtl/nm_cmd_sched.sv - shares two serial C2N command links between NREQ sources
module nm_cmd_sched
    import nm_cmd_pkg::*;
#(
    parameter  int NREQ  = 3,
    parameter  int CMD_W = CMD_W_DEF,
    parameter  int GAP   = 2,
    localparam int ID_W  = id_w(NREQ)
) (
    input  logic              PCLK,
    input  logic              PRESET,
    nm_cmd_sched_if.slave     req_if,
    output logic              C2N_DATA_0,
    output logic              C2N_VALID_0,
    output logic              C2N_DATA_1,
    output logic              C2N_VALID_1,
    output logic [1:0]        cmd_done,
    output logic [2*ID_W-1:0] cmd_done_id,
    output logic [1:0]        chan_busy
);

    localparam int BCW    = (CMD_W > 1) ? $clog2(CMD_W) : 1;
    localparam int GCW    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

    logic [1:0]      w_valid;
    logic [1:0]      w_data;
    logic [NREQ-1:0] w_grant [2];

    // A requester targets one channel only, so the two grant vectors are disjoint
    assign req_if.req_ready = (w_grant[0] | w_grant[1]) & {NREQ{~PRESET}};

    assign C2N_DATA_0  = w_data[0];
    assign C2N_VALID_0 = w_valid[0];
    assign C2N_DATA_1  = w_data[1];
    assign C2N_VALID_1 = w_valid[1];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        nm_ch_state_t    r_state;
        nm_ch_state_t    w_state_nxt;
        logic [CMD_W-1:0] r_sr;
        logic [BCW-1:0]  r_bitcnt;
        logic [GCW-1:0]  r_gapcnt;
        logic [ID_W-1:0] r_cur_id;
        logic            r_done;
        logic [ID_W-1:0] r_done_id;
        logic [NREQ-1:0] w_cand;
        logic [NREQ-1:0] w_arb_req;
        logic [NREQ-1:0] w_arb_grant;
        logic [ID_W-1:0] w_arb_idx;
        logic            w_accept;
        logic            w_last_bit;
        logic            w_ch_valid;
        logic [CMD_W-1:0] w_sel_cmd;

        // Requesters currently aiming at this channel
        always_comb begin
            w_cand = '0;
            for (int i = 0; i < NREQ; i++)
                w_cand[i] = req_if.req_valid[i] && (req_if.req_chan[i] == 1'(c));
        end

        // Only an idle channel offers a grant; reset suppresses acceptance
        assign w_arb_req  = w_cand & {NREQ{r_state == CH_IDLE}};
        assign w_accept   = (r_state == CH_IDLE) && (|w_cand) && !PRESET;
        assign w_sel_cmd  = req_if.req_cmd[w_arb_idx*CMD_W +: CMD_W];
        assign w_last_bit = (r_bitcnt == '0);

        nm_rr_arb #(.NREQ(NREQ)) u_arb (
            .PCLK      (PCLK),
            .PRESET    (PRESET),
            .i_req     (w_arb_req),
            .i_advance (w_accept),
            .o_grant   (w_arb_grant),
            .o_index   (w_arb_idx)
        );

        assign w_grant[c] = w_arb_grant;

        // Next state and line-valid for the serializer
        always_comb begin
            w_state_nxt = r_state;
            w_ch_valid  = 1'b0;
            case (r_state)
                CH_IDLE: begin
                    if (w_accept)
                        w_state_nxt = CH_SHIFT;
                end
                CH_SHIFT: begin
                    w_ch_valid = 1'b1;
                    if (w_last_bit)
                        w_state_nxt = (GAP > 0) ? CH_GAP : CH_IDLE;
                end
                CH_GAP: begin
                    if (r_gapcnt == '0)
                        w_state_nxt = CH_IDLE;
                end
                default: w_state_nxt = CH_IDLE;
            endcase
        end

        // State, shift register, counters and the registered done pulse
        always_ff @(posedge PCLK or posedge PRESET) begin
            if (PRESET) begin
                r_state   <= CH_IDLE;
                r_sr      <= '0;
                r_bitcnt  <= '0;
                r_gapcnt  <= '0;
                r_cur_id  <= '0;
                r_done    <= 1'b0;
                r_done_id <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_done  <= 1'b0;
                case (r_state)
                    CH_IDLE: begin
                        if (w_accept) begin
                            r_sr     <= w_sel_cmd;
                            r_bitcnt <= BCW'(CMD_W-1);
                            r_cur_id <= w_arb_idx;
                        end
                    end
                    CH_SHIFT: begin
                        r_sr     <= r_sr << 1;
                        r_bitcnt <= r_bitcnt - BCW'(1);
                        if (w_last_bit) begin
                            r_done    <= 1'b1;
                            r_done_id <= r_cur_id;
                            r_gapcnt  <= GCW'(GAP_M1);
                        end
                    end
                    CH_GAP: begin
                        r_gapcnt <= r_gapcnt - GCW'(1);
                    end
                    default: ;
                endcase
            end
        end

        assign w_valid[c]                    = w_ch_valid;
        assign w_data[c]                     = w_ch_valid & r_sr[CMD_W-1];
        assign chan_busy[c]                  = (r_state != CH_IDLE);
        assign cmd_done[c]                   = r_done;
        assign cmd_done_id[c*ID_W +: ID_W]   = r_done_id;
    end

endmodule

// File: tb/tb_nm_cmd_sched.sv
// tb/tb_nm_cmd_sched.sv - self-checking bench for nm_cmd_sched (GAP=2 and GAP=0 builds)
module tb_nm_cmd_sched;
    import nm_cmd_pkg::*;

    localparam int NREQ  = 3;
    localparam int CMD_W = 32;
    localparam int ID_W  = id_w(NREQ);

    typedef struct {int cyc; int d; int id; int ch;} acc_t;
    typedef struct {int id; int ch; logic [31:0] cmd; logic [31:0] exp_word; int exp_id; int exp_lat;} vec_t;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    logic [NREQ-1:0]       tv   [2];
    logic [NREQ-1:0]       tc   [2];
    logic [NREQ*CMD_W-1:0] tcmd [2];
    logic [1:0]            o_val [2], o_dat [2], o_done [2], o_busy [2];
    logic [2*ID_W-1:0]     o_did [2];
    logic [NREQ-1:0]       o_rdy [2];
    logic a_d0, a_v0, a_d1, a_v1, b_d0, b_v0, b_d1, b_v1;

    nm_cmd_sched_if #(.NREQ(NREQ), .CMD_W(CMD_W)) ifa ();
    nm_cmd_sched_if #(.NREQ(NREQ), .CMD_W(CMD_W)) ifb ();

    assign ifa.req_valid = tv[0];
    assign ifa.req_chan  = tc[0];
    assign ifa.req_cmd   = tcmd[0];
    assign ifb.req_valid = tv[1];
    assign ifb.req_chan  = tc[1];
    assign ifb.req_cmd   = tcmd[1];
    assign o_rdy[0] = ifa.req_ready;
    assign o_rdy[1] = ifb.req_ready;
    assign o_val[0] = {a_v1, a_v0};
    assign o_dat[0] = {a_d1, a_d0};
    assign o_val[1] = {b_v1, b_v0};
    assign o_dat[1] = {b_d1, b_d0};

    nm_cmd_sched #(.NREQ(NREQ), .CMD_W(CMD_W), .GAP(2)) dut_a (
        .PCLK(PCLK), .PRESET(PRESET), .req_if(ifa.slave),
        .C2N_DATA_0(a_d0), .C2N_VALID_0(a_v0), .C2N_DATA_1(a_d1), .C2N_VALID_1(a_v1),
        .cmd_done(o_done[0]), .cmd_done_id(o_did[0]), .chan_busy(o_busy[0]));

    nm_cmd_sched #(.NREQ(NREQ), .CMD_W(CMD_W), .GAP(0)) dut_b (
        .PCLK(PCLK), .PRESET(PRESET), .req_if(ifb.slave),
        .C2N_DATA_0(b_d0), .C2N_VALID_0(b_v0), .C2N_DATA_1(b_d1), .C2N_VALID_1(b_v1),
        .cmd_done(o_done[1]), .cmd_done_id(o_did[1]), .chan_busy(o_busy[1]));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode [2];
    logic [NREQ-1:0] acc_now [2];
    acc_t acc_log [$];

    // reference model: last accept per channel, next free cycle, round-robin pointer
    int m_ptr [2][2], m_free [2][2], m_t [2][2], m_id [2][2];
    logic [CMD_W-1:0] m_word [2][2];
    logic [NREQ-1:0] p_v [2], p_r [2], p_c [2];
    logic [NREQ*CMD_W-1:0] p_cmd [2];

    // capture of one channel of dut_a for table vectors
    int cap_en = 0, cap_ch = 0, cap_id = 0, cap_vcnt, cap_done_at, cap_acc_at, cap_done_id, cap_other;
    logic [31:0] cap_word;

    function automatic int gap_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset(input int d);
        for (int c = 0; c < 2; c++) begin
            m_ptr[d][c] = NREQ - 1;
            m_free[d][c] = 0;
            m_t[d][c] = -1000;
            m_id[d][c] = 0;
            m_word[d][c] = '0;
        end
    endtask

    task automatic model_cycle(input int d);
        int g, n, i;
        logic [NREQ-1:0] exp_rdy;
        logic ev, ed;
        g = gap_of(d);
        exp_rdy = '0;
        for (int k = 0; k < NREQ; k++)
            if (p_v[d][k] && !p_r[d][k] && tv[d][k])
                assert (tc[d][k] == p_c[d][k] && tcmd[d][k*CMD_W +: CMD_W] == p_cmd[d][k*CMD_W +: CMD_W])
                else $error("stimulus changed a waiting command");
        for (int c = 0; c < 2; c++) begin
            n  = cyc - m_t[d][c];
            ev = (n >= 1 && n <= CMD_W);
            ed = ev ? m_word[d][c][CMD_W-n] : 1'b0;
            chk("c2n_valid", o_val[d][c], ev);
            chk("c2n_data", o_dat[d][c], ed);
            chk("chan_busy", o_busy[d][c], (n >= 1 && n <= CMD_W + g));
            chk("cmd_done", o_done[d][c], (n == CMD_W + 1));
            if (n == CMD_W + 1)
                chk("cmd_done_id", o_did[d][c*ID_W +: ID_W], m_id[d][c]);
            if (cyc >= m_free[d][c]) begin
                for (int k = 1; k <= NREQ; k++) begin
                    i = (m_ptr[d][c] + k) % NREQ;
                    if (tv[d][i] && tc[d][i] == 1'(c)) begin
                        exp_rdy[i] = 1'b1;
                        break;
                    end
                end
            end
        end
        chk("req_ready", o_rdy[d], exp_rdy);
        for (int k = 0; k < NREQ; k++) begin
            if (exp_rdy[k] && tv[d][k]) begin
                i = int'(tc[d][k]);
                m_t[d][i] = cyc;
                m_word[d][i] = tcmd[d][k*CMD_W +: CMD_W];
                m_id[d][i] = k;
                m_ptr[d][i] = k;
                m_free[d][i] = cyc + CMD_W + g + 1;
            end
            if (o_rdy[d][k] && tv[d][k])
                acc_log.push_back('{cyc, d, k, int'(tc[d][k])});
        end
        acc_now[d] = o_rdy[d] & tv[d];
        p_v[d] = tv[d];
        p_r[d] = o_rdy[d];
        p_c[d] = tc[d];
        p_cmd[d] = tcmd[d];
    endtask

    task automatic update_stim(input int d);
        for (int i = 0; i < NREQ; i++) begin
            if (acc_now[d][i]) begin
                if (mode[d] == 1)
                    tv[d][i] = 1'b0;
                else if (mode[d] == 2) begin
                    tv[d][i] = 1'($urandom_range(1));
                    tc[d][i] = 1'($urandom_range(1));
                    tcmd[d][i*CMD_W +: CMD_W] = $urandom;
                end
            end else if (mode[d] == 2 && !tv[d][i] && $urandom_range(3) == 0) begin
                tv[d][i] = 1'b1;
                tc[d][i] = 1'($urandom_range(1));
                tcmd[d][i*CMD_W +: CMD_W] = $urandom;
            end
        end
        acc_now[d] = '0;
    endtask

    task automatic step();
        @(negedge PCLK);
        if (cap_en != 0) begin
            if (o_val[0][cap_ch]) begin
                cap_word = {cap_word[30:0], o_dat[0][cap_ch]};
                cap_vcnt++;
            end
            if (o_done[0][cap_ch]) begin
                cap_done_at = cyc;
                cap_done_id = int'(o_did[0][cap_ch*ID_W +: ID_W]);
            end
            if (cap_acc_at < 0 && o_rdy[0][cap_id] && tv[0][cap_id])
                cap_acc_at = cyc;
            if (o_val[0][1-cap_ch])
                cap_other++;
        end
        model_cycle(0);
        model_cycle(1);
        @(posedge PCLK);
        #1;
        cyc++;
        update_stim(0);
        update_stim(1);
    endtask

    vec_t vecs [6];
    int base, start, rel_cyc;

    initial begin
        vecs[0] = '{0, 0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 0, 33};
        vecs[1] = '{1, 1, 32'h1234_5678, 32'h1234_5678, 1, 33};
        vecs[2] = '{1, 0, 32'h8000_0000, 32'h8000_0000, 1, 33};
        vecs[3] = '{2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 33};
        vecs[4] = '{0, 1, 32'h0000_0000, 32'h0000_0000, 0, 33};
        vecs[5] = '{2, 0, 32'h0000_0001, 32'h0000_0001, 2, 33};

        for (int d = 0; d < 2; d++) begin
            tv[d] = '0; tc[d] = '0; tcmd[d] = '0; mode[d] = 1; acc_now[d] = '0;
            p_v[d] = '0; p_r[d] = '0; p_c[d] = '0; p_cmd[d] = '0;
            model_reset(d);
        end
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        tv[0] = 3'b111;
        #1;
        chk("reset_ready", o_rdy[0], 3'b000);
        chk("reset_valid", o_val[0], 2'b00);
        chk("reset_data", o_dat[0], 2'b00);
        chk("reset_done", o_done[0], 2'b00);
        chk("reset_done_id", o_did[0], '0);
        chk("reset_busy", o_busy[0], 2'b00);
        tv[0] = '0;
        PRESET = 1'b0;

        repeat (10) step();

        // single commands from the vector table
        cap_en = 1;
        for (int v = 0; v < 6; v++) begin
            cap_ch = vecs[v].ch; cap_id = vecs[v].id;
            cap_word = '0; cap_vcnt = 0; cap_done_at = -1; cap_acc_at = -1; cap_done_id = -1; cap_other = 0;
            tc[0][cap_id] = vecs[v].ch[0];
            tcmd[0][cap_id*CMD_W +: CMD_W] = vecs[v].cmd;
            tv[0][cap_id] = 1'b1;
            start = cyc;
            repeat (40) step();
            chk("vec_accept_cycle", cap_acc_at, start);
            chk("vec_word", cap_word, vecs[v].exp_word);
            chk("vec_valid_cycles", cap_vcnt, 32);
            chk("vec_done_latency", cap_done_at - cap_acc_at, vecs[v].exp_lat);
            chk("vec_done_id", cap_done_id, vecs[v].exp_id);
            chk("vec_other_chan_quiet", cap_other, 0);
        end
        cap_en = 0;

        // round robin between req0 and req2 held on ch0
        mode[0] = 0;
        base = acc_log.size();
        tc[0] = 3'b000; tcmd[0] = {32'hC0DE_0002, 32'h0, 32'hC0DE_0000};
        tv[0] = 3'b101;
        repeat (80) step();
        tv[0] = '0;
        repeat (40) step();
        chk("rr_count", acc_log.size() - base, 3);
        if (acc_log.size() >= base + 3) begin
            chk("rr_first", acc_log[base].id, 0);
            chk("rr_second", acc_log[base+1].id, 2);
            chk("rr_third", acc_log[base+2].id, 0);
            chk("rr_pitch", acc_log[base+1].cyc - acc_log[base].cyc, 35);
            chk("rr_pitch2", acc_log[base+2].cyc - acc_log[base+1].cyc, 35);
        end

        // both channels start in the same cycle
        mode[0] = 1;
        base = acc_log.size();
        tc[0] = 3'b100; tcmd[0] = {32'h8000_0000, 32'h0000_0001, 32'h0};
        tv[0] = 3'b110;
        repeat (40) step();
        chk("dual_count", acc_log.size() - base, 2);
        if (acc_log.size() >= base + 2)
            chk("dual_same_cycle", acc_log[base+1].cyc - acc_log[base].cyc, 0);

        // three requesters on ch1
        mode[0] = 0;
        base = acc_log.size();
        tc[0] = 3'b111; tcmd[0] = {32'h2222_2222, 32'h1111_1111, 32'h0F0F_0F0F};
        tv[0] = 3'b111;
        repeat (110) step();
        tv[0] = '0;
        repeat (40) step();
        chk("ch1_count", acc_log.size() - base, 4);
        if (acc_log.size() >= base + 4) begin
            for (int k = 0; k < 4; k++)
                chk("ch1_order", acc_log[base+k].id, k % 3);
            for (int k = 1; k < 4; k++)
                chk("ch1_pitch", acc_log[base+k].cyc - acc_log[base+k-1].cyc, 35);
        end

        // reset in the 20th shift cycle aborts, then req0 is re-accepted
        base = acc_log.size();
        tc[0] = 3'b000; tcmd[0][CMD_W-1:0] = 32'h5A5A_C3C3;
        tv[0] = 3'b001;
        step();
        chk("abort_accept", acc_log.size() - base, 1);
        repeat (19) step();
        chk("abort_pre_valid", o_val[0][0], 1'b1);
        PRESET = 1'b1;
        #1;
        chk("abort_valid", o_val[0][0], 1'b0);
        chk("abort_data", o_dat[0][0], 1'b0);
        chk("abort_busy", o_busy[0], 2'b00);
        chk("abort_ready", o_rdy[0], 3'b000);
        repeat (2) @(posedge PCLK);
        #1;
        chk("abort_no_done", o_done[0], 2'b00);
        model_reset(0);
        model_reset(1);
        mode[0] = 1;
        PRESET = 1'b0;
        rel_cyc = cyc;
        base = acc_log.size();
        step();
        chk("abort_reaccept", acc_log.size() - base, 1);
        if (acc_log.size() > base)
            chk("abort_reaccept_cycle", acc_log[base].cyc, rel_cyc);
        repeat (40) step();

        // GAP=0 build, back-to-back on ch0
        mode[1] = 0;
        base = acc_log.size();
        tc[1] = 3'b000; tcmd[1][CMD_W-1:0] = 32'hF00F_9669;
        tv[1] = 3'b001;
        repeat (70) step();
        tv[1] = '0;
        repeat (40) step();
        chk("gap0_count", acc_log.size() - base, 3);
        if (acc_log.size() >= base + 2)
            chk("gap0_pitch", acc_log[base+1].cyc - acc_log[base].cyc, 33);

        // randomized traffic on both builds
        mode[0] = 2;
        mode[1] = 2;
        repeat (3000) step();
        mode[0] = 0;
        mode[1] = 0;
        tv[0] = '0;
        tv[1] = '0;
        repeat (40) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
